// File: rtl/scan_preprocess_mc.sv
// Sync pulse timestamping with glitch rejection, scan direction/midpoint/period
// derivation, and per-channel first-word-fall-through groove edge FIFOs.
module scan_preprocess_mc #(
   parameter int TW       = 32,
   parameter int NCH      = 2,
   parameter int DEPTH    = 8,
   parameter int MIN_SYNC = 4
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              lsync,
   input  logic              rsync,
   input  logic [NCH-1:0]    sig,
   output logic              sync_start,
   output logic              dir,
   output logic              sync_err,
   output logic [TW-1:0]     sync_mid_time,
   output logic [TW-1:0]     t_ltr,
   output logic [TW-1:0]     t_rtl,
   output logic              period_valid,
   output logic [NCH*TW-1:0] ev_time,
   output logic [NCH-1:0]    ev_rise,
   output logic [NCH-1:0]    ev_dir,
   output logic [NCH-1:0]    ev_valid,
   input  logic [NCH-1:0]    ev_ready,
   output logic [NCH-1:0]    ovf
);

   localparam int         AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [7:0] MINW = 8'(MIN_SYNC);

   logic [TW-1:0]  timer_q;
   logic           lprev_q, rprev_q;
   logic [7:0]     lwidth_q, rwidth_q;
   logic [TW-1:0]  lrise_q, rrise_q;
   logic [NCH-1:0] sig_prev_q;

   logic           sync_start_q, sync_err_q, dir_q, period_valid_q;
   logic [TW-1:0]  mid_q, t_ltr_q, t_rtl_q;
   logic [TW-1:0]  last_fall_q;
   logic           last_side_q, have_last_q;

   logic           l_acc, r_acc, acc_side, both_acc;
   logic [TW-1:0]  sel_rise, high_span, mid_d, since_last;

   assign l_acc      = !lsync && lprev_q && (lwidth_q >= MINW);
   assign r_acc      = !rsync && rprev_q && (rwidth_q >= MINW);
   assign both_acc   = l_acc && r_acc;
   // lsync has priority when both sides fall together
   assign acc_side   = !l_acc;
   assign sel_rise   = l_acc ? lrise_q : rrise_q;
   assign high_span  = timer_q - sel_rise;
   assign mid_d      = sel_rise + (high_span >> 1);
   assign since_last = timer_q - last_fall_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         timer_q        <= '0;
         lprev_q        <= 1'b0;
         rprev_q        <= 1'b0;
         lwidth_q       <= '0;
         rwidth_q       <= '0;
         lrise_q        <= '0;
         rrise_q        <= '0;
         sig_prev_q     <= '0;
         sync_start_q   <= 1'b0;
         sync_err_q     <= 1'b0;
         dir_q          <= 1'b0;
         period_valid_q <= 1'b0;
         mid_q          <= '0;
         t_ltr_q        <= '0;
         t_rtl_q        <= '0;
         last_fall_q    <= '0;
         last_side_q    <= 1'b0;
         have_last_q    <= 1'b0;
      end else begin
         timer_q    <= timer_q + TW'(1);
         lprev_q    <= lsync;
         rprev_q    <= rsync;
         sig_prev_q <= sig;

         if (lsync && !lprev_q) begin
            lrise_q  <= timer_q;
            lwidth_q <= 8'd1;
         end else if (lsync && (lwidth_q < MINW)) begin
            lwidth_q <= lwidth_q + 8'd1;
         end

         if (rsync && !rprev_q) begin
            rrise_q  <= timer_q;
            rwidth_q <= 8'd1;
         end else if (rsync && (rwidth_q < MINW)) begin
            rwidth_q <= rwidth_q + 8'd1;
         end

         sync_start_q   <= l_acc || r_acc;
         sync_err_q     <= both_acc;
         period_valid_q <= 1'b0;

         if (l_acc || r_acc) begin
            dir_q       <= acc_side;
            mid_q       <= mid_d;
            last_fall_q <= timer_q;
            last_side_q <= acc_side;
            have_last_q <= 1'b1;
            // a period needs an opposite-side predecessor and an unambiguous fall
            if (have_last_q && !both_acc && (last_side_q != acc_side)) begin
               period_valid_q <= 1'b1;
               if (acc_side) t_ltr_q <= since_last;
               else          t_rtl_q <= since_last;
            end
         end
      end
   end

   assign sync_start    = sync_start_q;
   assign sync_err      = sync_err_q;
   assign dir           = dir_q;
   assign sync_mid_time = mid_q;
   assign t_ltr         = t_ltr_q;
   assign t_rtl         = t_rtl_q;
   assign period_valid  = period_valid_q;

   for (genvar k = 0; k < NCH; k++) begin : g_ch
      logic [TW+1:0] mem_q [DEPTH];
      logic [AW-1:0] wr_q, rd_q;
      logic [AW:0]   cnt_q;
      logic          ovf_q;
      logic          edge_k, empty, full, pop, push, drop;
      logic [TW+1:0] head;

      assign edge_k = sig[k] ^ sig_prev_q[k];
      assign empty  = (cnt_q == '0);
      assign full   = (cnt_q == (AW+1)'(DEPTH));
      assign pop    = !empty && ev_ready[k];
      // a pop on a full FIFO frees the slot for the same-cycle push
      assign push   = edge_k && (!full || pop);
      assign drop   = edge_k && full && !pop;
      assign head   = mem_q[rd_q];

      always_ff @(posedge clk) begin
         if (push) mem_q[wr_q] <= {timer_q, sig[k], dir_q};
      end

      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
         end else begin
            if (push) wr_q <= wr_q + AW'(1);
            if (pop)  rd_q <= rd_q + AW'(1);
            case ({push, pop})
               2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
               2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
               default: cnt_q <= cnt_q;
            endcase
            if (drop)              ovf_q <= 1'b1;
            else if (sync_start_q) ovf_q <= 1'b0;
         end
      end

      assign ev_valid[k]          = !empty;
      assign ev_time[k*TW +: TW]  = empty ? '0 : head[TW+1:2];
      assign ev_rise[k]           = !empty && head[1];
      assign ev_dir[k]            = !empty && head[0];
      assign ovf[k]               = ovf_q;
   end

endmodule
